sec_a2b_iter: RTL

//  Iterative masked arithmetic-to-Boolean converter: the inverse of the B2A path in the masking library.

---
 rtl/sec_mask_pkg.sv | 34 +++
 rtl/sec_and.sv | 58 +++++
 rtl/sec_a2b_iter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sec_mask_pkg.sv
// rtl/sec_mask_pkg.sv - shared types and constants for the masked A2B converter
// Build option: SEC_A2B_REFRESH_EN adds the REFR state and one cycle of latency.
package sec_mask_pkg;

  localparam int K_WIDTH_DEF  = 32;
  localparam int N_SHARES_DEF = 3;

  // Kogge-Stone rounds per addition and random words per DOM AND at the default sizes
  localparam int LOG_K    = $clog2(K_WIDTH_DEF);
  localparam int RAND_AND = N_SHARES_DEF * (N_SHARES_DEF - 1) / 2;

  // Accept edge to o_dvld, with i_rvld held high
`ifdef SEC_A2B_REFRESH_EN
  localparam int LATENCY = 2 + (N_SHARES_DEF - 1) * (LOG_K + 2);
`else
  localparam int LATENCY = 1 + (N_SHARES_DEF - 1) * (LOG_K + 2);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GEN,
    ST_KS,
    ST_FIN,
    ST_OUT,
    ST_REFR
  } a2b_state_e;

  // Slot of the random word shared by share pair (i, j), i < j, in row-major upper-triangle order
  function automatic int pair_idx(input int n, input int i, input int j);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/sec_and.sv
// rtl/sec_and.sv - N-share DOM AND gadget with one register stage and a step enable
module sec_and
  import sec_mask_pkg::*;
#(
  parameter int  K_WIDTH  = K_WIDTH_DEF,
  parameter int  N_SHARES = N_SHARES_DEF,
  localparam int RA       = N_SHARES * (N_SHARES - 1) / 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        i_en,
  input  logic [N_SHARES*K_WIDTH-1:0] i_x,
  input  logic [N_SHARES*K_WIDTH-1:0] i_y,
  input  logic [RA*K_WIDTH-1:0]       i_r,
  output logic [N_SHARES*K_WIDTH-1:0] o_z
);

  logic [K_WIDTH-1:0] t_d [N_SHARES][N_SHARES];
  logic [K_WIDTH-1:0] t_q [N_SHARES][N_SHARES];

  // Partial products; each cross-domain term is blinded by the word it shares with its mirror term
  always_comb begin
    for (int i = 0; i < N_SHARES; i++) begin
      for (int j = 0; j < N_SHARES; j++) begin
        t_d[i][j] = i_x[i*K_WIDTH +: K_WIDTH] & i_y[j*K_WIDTH +: K_WIDTH];
        if (i < j) begin
          t_d[i][j] = t_d[i][j] ^ i_r[pair_idx(N_SHARES, i, j)*K_WIDTH +: K_WIDTH];
        end else if (i > j) begin
          t_d[i][j] = t_d[i][j] ^ i_r[pair_idx(N_SHARES, j, i)*K_WIDTH +: K_WIDTH];
        end
      end
    end
  end

  // Register every term before any recombination so no glitch can combine domains
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_SHARES; i++) begin
      for (int j = 0; j < N_SHARES; j++) begin
        if (!rst_ni) begin
          t_q[i][j] <= '0;
        end else if (i_en) begin
          t_q[i][j] <= t_d[i][j];
        end
      end
    end
  end

  // Compress the registered terms of each domain into its output share
  always_comb begin
    o_z = '0;
    for (int i = 0; i < N_SHARES; i++) begin
      for (int j = 0; j < N_SHARES; j++) begin
        o_z[i*K_WIDTH +: K_WIDTH] = o_z[i*K_WIDTH +: K_WIDTH] ^ t_q[i][j];
      end
    end
  end

endmodule

// File: rtl/sec_a2b_iter.sv
// rtl/sec_a2b_iter.sv - iterative masked arithmetic-to-Boolean converter (option: SEC_A2B_REFRESH_EN)
module sec_a2b_iter
  import sec_mask_pkg::*;
#(
  parameter int  K_WIDTH  = K_WIDTH_DEF,
  parameter int  N_SHARES = N_SHARES_DEF,
  localparam int RA       = N_SHARES * (N_SHARES - 1) / 2,
  localparam int LK       = $clog2(K_WIDTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        i_dvld,
  input  logic                        i_rvld,
  input  logic [2*RA*K_WIDTH-1:0]     i_n,
  input  logic [N_SHARES*K_WIDTH-1:0] i_a,
  output logic                        o_rdy,
  output logic [N_SHARES*K_WIDTH-1:0] o_z,
  output logic                        o_dvld
);

  localparam int NK = N_SHARES * K_WIDTH;
  localparam int RK = RA * K_WIDTH;
  localparam int JW = $clog2(N_SHARES);
  localparam int RW = $clog2(LK + 1);

  a2b_state_e      state_q, state_d;
  logic [NK-1:0]   a_q, a_d, x_q, x_d, y_q, y_d, p_q, p_d, gacc_q, gacc_d, z_q, z_d;
  logic [JW-1:0]   j_q, j_d;
  logic [RW-1:0]   r_q, r_d;
  logic            dvld_q, dvld_d;

  logic [NK-1:0]   p_cur, g_cur, y_new, sum_new, p_sh, g_sh, gand_x, gand_y, gand_z, pand_z;
  logic            gand_en, pand_en;

  // Current propagate/generate sharings and the operands for this step's two AND gadgets
  always_comb begin
    p_cur   = (r_q == '0) ? p_q : pand_z;
    g_cur   = gacc_q ^ gand_z;
    y_new   = '0;
    y_new[K_WIDTH-1:0] = a_q[j_q*K_WIDTH +: K_WIDTH];
    p_sh    = '0;
    g_sh    = '0;
    sum_new = '0;
    for (int i = 0; i < N_SHARES; i++) begin
      p_sh[i*K_WIDTH +: K_WIDTH]    = p_cur[i*K_WIDTH +: K_WIDTH] << (1 << r_q);
      g_sh[i*K_WIDTH +: K_WIDTH]    = g_cur[i*K_WIDTH +: K_WIDTH] << (1 << r_q);
      sum_new[i*K_WIDTH +: K_WIDTH] = x_q[i*K_WIDTH +: K_WIDTH] ^ y_q[i*K_WIDTH +: K_WIDTH]
                                      ^ (g_cur[i*K_WIDTH +: K_WIDTH] << 1);
    end
    gand_x  = (state_q == ST_GEN) ? x_q   : p_cur;
    gand_y  = (state_q == ST_GEN) ? y_new : g_sh;
    gand_en = i_rvld & ((state_q == ST_GEN) | (state_q == ST_KS));
    pand_en = i_rvld & (state_q == ST_KS);
  end

  sec_and #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES)) u_and_g (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .i_en  (gand_en),
    .i_x   (gand_x),
    .i_y   (gand_y),
    .i_r   (i_n[0 +: RK]),
    .o_z   (gand_z)
  );

  sec_and #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES)) u_and_p (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .i_en  (pand_en),
    .i_x   (p_cur),
    .i_y   (p_sh),
    .i_r   (i_n[RK +: RK]),
    .o_z   (pand_z)
  );

`ifdef SEC_A2B_REFRESH_EN
  logic [NK-1:0] z_refr;

  // Re-randomise the result: fresh words on the first N-1 shares, their XOR folded into the last
  always_comb begin
    z_refr = x_q;
    for (int i = 0; i < N_SHARES - 1; i++) begin
      z_refr[i*K_WIDTH +: K_WIDTH] = z_refr[i*K_WIDTH +: K_WIDTH] ^ i_n[i*K_WIDTH +: K_WIDTH];
      z_refr[(N_SHARES-1)*K_WIDTH +: K_WIDTH] =
        z_refr[(N_SHARES-1)*K_WIDTH +: K_WIDTH] ^ i_n[i*K_WIDTH +: K_WIDTH];
    end
  end
`endif

  // Sequencer: fold one arithmetic share per pass; nothing moves while randomness is not valid
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    p_d     = p_q;
    gacc_d  = gacc_q;
    z_d     = z_q;
    j_d     = j_q;
    r_d     = r_q;
    dvld_d  = dvld_q;
    if (i_rvld) begin
      case (state_q)
        ST_IDLE: begin
          if (i_dvld) begin
            a_d     = i_a;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          x_d                = '0;
          x_d[K_WIDTH-1:0]   = a_q[K_WIDTH-1:0];
          j_d                = JW'(1);
          state_d            = ST_GEN;
        end
        ST_GEN: begin
          y_d     = y_new;
          p_d     = x_q ^ y_new;
          gacc_d  = '0;
          r_d     = '0;
          state_d = ST_KS;
        end
        ST_KS: begin
          gacc_d = g_cur;
          r_d    = r_q + 1'b1;
          if (r_q == RW'(LK - 1)) state_d = ST_FIN;
        end
        ST_FIN: begin
          x_d = sum_new;
          j_d = j_q + 1'b1;
          if (j_q < JW'(N_SHARES - 1)) begin
            state_d = ST_GEN;
          end else begin
`ifdef SEC_A2B_REFRESH_EN
            state_d = ST_REFR;
`else
            z_d     = sum_new;
            dvld_d  = 1'b1;
            state_d = ST_OUT;
`endif
          end
        end
`ifdef SEC_A2B_REFRESH_EN
        ST_REFR: begin
          z_d     = z_refr;
          dvld_d  = 1'b1;
          state_d = ST_OUT;
        end
`endif
        ST_OUT: begin
          dvld_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      gacc_q  <= '0;
      z_q     <= '0;
      j_q     <= '0;
      r_q     <= '0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      gacc_q  <= gacc_d;
      z_q     <= z_d;
      j_q     <= j_d;
      r_q     <= r_d;
      dvld_q  <= dvld_d;
    end
  end

  assign o_rdy  = (state_q == ST_IDLE);
  assign o_z    = z_q;
  assign o_dvld = dvld_q;

endmodule
